// File: rtl/riscv_pcr_file.sv
// Privileged control register file: trap state, cycle counter with compare timer,
// interrupt pending/request logic, scratch registers and host mailboxes.
module riscv_pcr_file #(
  parameter int XLEN        = 64,
  parameter int COREID      = 0,
  parameter int HAS_FPU     = 0,
  parameter int HAS_VECTOR  = 0,
  parameter int NUM_SCRATCH = 2,
  parameter int NUM_HOST_CH = 1,
  parameter int LG_MEMSIZE  = 26
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [7:0]             status,
  output logic                   error_mode,
  output logic                   log_control,
  output logic [7:0]             vec_bank,
  output logic [3:0]             vec_bank_count,
  input  logic [6:0]             irq_ext,
  output logic                   interrupt,
  output logic [4:0]             interrupt_cause,
  input  logic                   exception,
  input  logic [4:0]             cause,
  input  logic [XLEN-1:0]        pc,
  input  logic                   badvaddr_wen,
  input  logic [XLEN-1:0]        badvaddr,
  input  logic                   eret,
  input  logic [4:0]             raddr,
  input  logic                   ren,
  output logic [XLEN-1:0]        rdata,
  input  logic [4:0]             waddr,
  input  logic                   wen,
  input  logic [XLEN-1:0]        wdata,
  input  logic                   htif_fromhost_wen,
  input  logic [2:0]             htif_ch,
  input  logic [31:0]            htif_fromhost,
  output logic [31:0]            htif_tohost,
  output logic [NUM_HOST_CH-1:0] htif_tohost_valid
);

  localparam logic [4:0] A_STATUS   = 5'd0;
  localparam logic [4:0] A_EPC      = 5'd1;
  localparam logic [4:0] A_BADVADDR = 5'd2;
  localparam logic [4:0] A_EVEC     = 5'd3;
  localparam logic [4:0] A_COUNT    = 5'd4;
  localparam logic [4:0] A_COMPARE  = 5'd5;
  localparam logic [4:0] A_CAUSE    = 5'd6;
  localparam logic [4:0] A_IP       = 5'd7;
  localparam logic [4:0] A_MEMSIZE  = 5'd8;
  localparam logic [4:0] A_VECBANK  = 5'd9;
  localparam logic [4:0] A_COREID   = 5'd10;
  localparam logic [4:0] A_LOG      = 5'd11;
  localparam logic [4:0] A_K0       = 5'd12;
  localparam logic [4:0] A_TOHOST0  = 5'd16;
  localparam logic [4:0] A_FROMHOST0 = 5'd24;

  // status bit positions: {SX,UX,S,PS,0,EV,EF,ET}
  localparam int B_S  = 5;
  localparam int B_PS = 4;
  localparam int B_ET = 0;

  localparam logic            EV_EN       = (HAS_VECTOR != 0);
  localparam logic            EF_EN       = (HAS_FPU != 0);
  localparam logic [7:0]      COREID_V    = 8'(COREID);
  localparam logic [XLEN-1:0] MEMSIZE_V   = XLEN'(1) << LG_MEMSIZE;

  logic [7:0]      status_q, status_d;
  logic [7:0]      im_q, im_d;
  logic            error_mode_q, error_mode_d;
  logic            log_q, log_d;
  logic [7:0]      vec_bank_q, vec_bank_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] badvaddr_q, badvaddr_d;
  logic [XLEN-1:0] evec_q, evec_d;
  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] compare_q, compare_d;
  logic [4:0]      cause_q, cause_d;
  logic            timer_pend_q, timer_pend_d;
  logic [6:0]      irq_q, irq_d;
  logic [XLEN-1:0] scratch_q [NUM_SCRATCH];
  logic [XLEN-1:0] scratch_d [NUM_SCRATCH];
  logic [31:0]     tohost_q [NUM_HOST_CH];
  logic [31:0]     tohost_d [NUM_HOST_CH];
  logic [31:0]     fromhost_q [NUM_HOST_CH];
  logic [31:0]     fromhost_d [NUM_HOST_CH];

  logic [XLEN-1:0] count_inc;
  logic            wen_eff;
  logic [7:0]      pend_vec;

  // Trap handling outranks eret, which outranks software writes.
  always_comb begin
    status_d     = status_q;
    im_d         = im_q;
    error_mode_d = error_mode_q;
    log_d        = log_q;
    vec_bank_d   = vec_bank_q;
    epc_d        = epc_q;
    badvaddr_d   = badvaddr_q;
    evec_d       = evec_q;
    compare_d    = compare_q;
    cause_d      = cause_q;
    scratch_d    = scratch_q;
    irq_d        = irq_ext;
    count_inc    = count_q + XLEN'(1);
    count_d      = count_inc;
    timer_pend_d = timer_pend_q | (count_inc == compare_q);
    wen_eff      = wen & ~exception & ~eret;

    if (exception) begin
      if (!status_q[B_ET]) begin
        error_mode_d = 1'b1;
      end else begin
        status_d[B_S]  = 1'b1;
        status_d[B_PS] = status_q[B_S];
        status_d[B_ET] = 1'b0;
        epc_d          = pc;
        cause_d        = cause;
        if (badvaddr_wen) badvaddr_d = badvaddr;
      end
    end else if (eret) begin
      status_d[B_S]  = status_q[B_PS];
      status_d[B_ET] = 1'b1;
    end else if (wen) begin
      case (waddr)
        A_STATUS: begin
          status_d = {wdata[7:4], 1'b0, EV_EN & wdata[2], EF_EN & wdata[1], wdata[0]};
          im_d     = wdata[15:8];
        end
        A_EPC:      epc_d      = wdata;
        A_BADVADDR: badvaddr_d = wdata;
        A_EVEC:     evec_d     = wdata;
        A_COUNT:    count_d    = wdata;
        A_COMPARE: begin
          compare_d    = wdata;
          timer_pend_d = 1'b0;
        end
        A_CAUSE:    cause_d    = wdata[4:0];
        A_VECBANK:  vec_bank_d = wdata[7:0];
        A_LOG:      log_d      = wdata[0];
        default: ;
      endcase
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (waddr == 5'(int'(A_K0) + i)) scratch_d[i] = wdata;
      end
    end
  end

  // A host write to a channel beats any core write to the same channel.
  always_comb begin
    tohost_d   = tohost_q;
    fromhost_d = fromhost_q;
    for (int c = 0; c < NUM_HOST_CH; c++) begin
      if (htif_fromhost_wen && (htif_ch == 3'(c))) begin
        fromhost_d[c] = htif_fromhost;
        tohost_d[c]   = '0;
      end else if (wen_eff && (waddr == 5'(int'(A_TOHOST0) + c))) begin
        tohost_d[c]   = wdata[31:0];
        fromhost_d[c] = '0;
      end else if (wen_eff && (waddr == 5'(int'(A_FROMHOST0) + c))) begin
        fromhost_d[c] = wdata[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q     <= 8'hE0;
      im_q         <= '0;
      error_mode_q <= 1'b0;
      log_q        <= 1'b0;
      vec_bank_q   <= 8'hFF;
      epc_q        <= '0;
      badvaddr_q   <= '0;
      evec_q       <= '0;
      count_q      <= '0;
      compare_q    <= '0;
      cause_q      <= '0;
      timer_pend_q <= 1'b0;
      irq_q        <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
      for (int c = 0; c < NUM_HOST_CH; c++) begin
        tohost_q[c]   <= '0;
        fromhost_q[c] <= '0;
      end
    end else begin
      status_q     <= status_d;
      im_q         <= im_d;
      error_mode_q <= error_mode_d;
      log_q        <= log_d;
      vec_bank_q   <= vec_bank_d;
      epc_q        <= epc_d;
      badvaddr_q   <= badvaddr_d;
      evec_q       <= evec_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      cause_q      <= cause_d;
      timer_pend_q <= timer_pend_d;
      irq_q        <= irq_d;
      scratch_q    <= scratch_d;
      tohost_q     <= tohost_d;
      fromhost_q   <= fromhost_d;
    end
  end

  // Mailboxes are 32 bits wide and sign-extend on read.
  always_comb begin
    rdata = '0;
    if (ren) begin
      case (raddr)
        A_STATUS:   rdata = XLEN'({im_q, status_q});
        A_EPC:      rdata = epc_q;
        A_BADVADDR: rdata = badvaddr_q;
        A_EVEC:     rdata = evec_q;
        A_COUNT:    rdata = count_q;
        A_COMPARE:  rdata = compare_q;
        A_CAUSE:    rdata = XLEN'(cause_q);
        A_IP:       rdata = XLEN'({timer_pend_q, irq_q});
        A_MEMSIZE:  rdata = MEMSIZE_V;
        A_VECBANK:  rdata = XLEN'(vec_bank_q);
        A_COREID:   rdata = XLEN'(COREID_V);
        A_LOG:      rdata = XLEN'(log_q);
        default:    rdata = '0;
      endcase
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (raddr == 5'(int'(A_K0) + i)) rdata = scratch_q[i];
      end
      for (int c = 0; c < NUM_HOST_CH; c++) begin
        if (raddr == 5'(int'(A_TOHOST0) + c))   rdata = XLEN'($signed(tohost_q[c]));
        if (raddr == 5'(int'(A_FROMHOST0) + c)) rdata = XLEN'($signed(fromhost_q[c]));
      end
    end
  end

  always_comb begin
    htif_tohost = '0;
    for (int c = 0; c < NUM_HOST_CH; c++) begin
      htif_tohost_valid[c] = |tohost_q[c];
      if ((htif_ch == 3'(c)) && !htif_fromhost_wen) htif_tohost = tohost_q[c];
    end
  end

  // Lowest pending index wins, so scan from the top down.
  always_comb begin
    pend_vec        = im_q & {timer_pend_q, irq_q};
    interrupt       = status_q[B_ET] & (|pend_vec);
    interrupt_cause = '0;
    if (interrupt) begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_vec[i]) interrupt_cause = 5'(16 + i);
      end
    end
  end

  assign status         = status_q;
  assign error_mode     = error_mode_q;
  assign log_control    = log_q;
  assign vec_bank       = vec_bank_q;
  assign vec_bank_count = 4'($countones(vec_bank_q));

endmodule

// File: tb/tb_riscv_pcr_file.sv
// Bench for riscv_pcr_file: a 64-bit two-channel instance plus a 32-bit
// single-channel instance driven from the same stimulus.
module tb_riscv_pcr_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  irq_ext;
  logic        exception;
  logic [4:0]  cause;
  logic [63:0] pc;
  logic        badvaddr_wen;
  logic [63:0] badvaddr;
  logic        eret;
  logic [4:0]  raddr;
  logic        ren;
  logic [4:0]  waddr;
  logic        wen;
  logic [63:0] wdata;
  logic        htif_fromhost_wen;
  logic [2:0]  htif_ch;
  logic [31:0] htif_fromhost;

  logic [7:0]  status, status32;
  logic        error_mode, error32;
  logic        log_control, log32;
  logic [7:0]  vec_bank, vb32;
  logic [3:0]  vec_bank_count, vbc32;
  logic        interrupt, int32;
  logic [4:0]  interrupt_cause, ic32;
  logic [63:0] rdata;
  logic [31:0] rdata32;
  logic [31:0] htif_tohost, tohost32;
  logic [1:0]  htif_tohost_valid;
  logic [0:0]  valid32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_pcr_file #(.XLEN(64), .COREID(3), .HAS_FPU(1), .HAS_VECTOR(0),
                   .NUM_SCRATCH(2), .NUM_HOST_CH(2), .LG_MEMSIZE(26)) dut (
    .clk(clk), .reset_n(reset_n), .status(status), .error_mode(error_mode),
    .log_control(log_control), .vec_bank(vec_bank), .vec_bank_count(vec_bank_count),
    .irq_ext(irq_ext), .interrupt(interrupt), .interrupt_cause(interrupt_cause),
    .exception(exception), .cause(cause), .pc(pc), .badvaddr_wen(badvaddr_wen),
    .badvaddr(badvaddr), .eret(eret), .raddr(raddr), .ren(ren), .rdata(rdata),
    .waddr(waddr), .wen(wen), .wdata(wdata), .htif_fromhost_wen(htif_fromhost_wen),
    .htif_ch(htif_ch), .htif_fromhost(htif_fromhost), .htif_tohost(htif_tohost),
    .htif_tohost_valid(htif_tohost_valid)
  );

  riscv_pcr_file #(.XLEN(32), .COREID(5), .HAS_FPU(0), .HAS_VECTOR(0),
                   .NUM_SCRATCH(2), .NUM_HOST_CH(1), .LG_MEMSIZE(26)) dut32 (
    .clk(clk), .reset_n(reset_n), .status(status32), .error_mode(error32),
    .log_control(log32), .vec_bank(vb32), .vec_bank_count(vbc32),
    .irq_ext(irq_ext), .interrupt(int32), .interrupt_cause(ic32),
    .exception(exception), .cause(cause), .pc(pc[31:0]), .badvaddr_wen(badvaddr_wen),
    .badvaddr(badvaddr[31:0]), .eret(eret), .raddr(raddr), .ren(ren), .rdata(rdata32),
    .waddr(waddr), .wen(wen), .wdata(wdata[31:0]), .htif_fromhost_wen(htif_fromhost_wen),
    .htif_ch(htif_ch), .htif_fromhost(htif_fromhost), .htif_tohost(tohost32),
    .htif_tohost_valid(valid32)
  );

  typedef struct {
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [4:0]  raddr;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    wen = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [4:0] a, input logic [63:0] exp);
    raddr = a; ren = 1'b1;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic rd32_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    raddr = a; ren = 1'b1;
    #1;
    check(name, {32'b0, rdata32}, {32'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    tbl[0]  = '{5'd1,  64'h1234_5678_9abc_def0, 5'd1,  64'h1234_5678_9abc_def0};
    tbl[1]  = '{5'd2,  64'hdead_beef_0000_0001, 5'd2,  64'hdead_beef_0000_0001};
    tbl[2]  = '{5'd3,  64'h8000_0000_0000_0100, 5'd3,  64'h8000_0000_0000_0100};
    tbl[3]  = '{5'd6,  64'hffff,                5'd6,  64'h1f};
    tbl[4]  = '{5'd9,  64'h1234,                5'd9,  64'h34};
    tbl[5]  = '{5'd11, 64'h3,                   5'd11, 64'h1};
    tbl[6]  = '{5'd12, 64'haaaa_5555_aaaa_5555, 5'd12, 64'haaaa_5555_aaaa_5555};
    tbl[7]  = '{5'd13, 64'h1,                   5'd13, 64'h1};
    tbl[8]  = '{5'd14, 64'hffff,                5'd14, 64'h0};
    tbl[9]  = '{5'd8,  64'h5,                   5'd8,  64'h400_0000};
    tbl[10] = '{5'd10, 64'hff,                  5'd10, 64'h3};
    tbl[11] = '{5'd7,  64'hff,                  5'd7,  64'h0};
    tbl[12] = '{5'd17, 64'h1_8000_0001,         5'd17, 64'hffff_ffff_8000_0001};
    tbl[13] = '{5'd24, 64'h7fff_ffff,           5'd24, 64'h7fff_ffff};
    tbl[14] = '{5'd18, 64'h5,                   5'd18, 64'h0};
    tbl[15] = '{5'd26, 64'h5,                   5'd26, 64'h0};
    tbl[16] = '{5'd5,  64'hffff_ffff_0000_0000, 5'd5,  64'hffff_ffff_0000_0000};
    tbl[17] = '{5'd0,  64'hab_ff,               5'd0,  64'hab_f3};

    reset_n = 1'b0; irq_ext = '0; exception = 1'b0; cause = '0; pc = '0;
    badvaddr_wen = 1'b0; badvaddr = '0; eret = 1'b0; raddr = '0; ren = 1'b0;
    waddr = '0; wen = 1'b0; wdata = '0; htif_fromhost_wen = 1'b0; htif_ch = '0;
    htif_fromhost = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // ---- mid-run asynchronous reset ----
    wr(5'd9, 64'h0f);
    wr(5'd0, 64'h01);
    #1;
    check("pre_rst_vbc", 64'(vec_bank_count), 64'd4);
    check("pre_rst_status", 64'(status), 64'h01);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_status", 64'(status), 64'he0);
    check("rst_vbc", 64'(vec_bank_count), 64'd8);
    check("rst_vec_bank", 64'(vec_bank), 64'hff);
    check("rst_err", 64'(error_mode), 64'd0);
    check("rst_int", 64'(interrupt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_check("count_0", 5'd4, 64'd0);
    @(negedge clk);
    rd_check("count_1", 5'd4, 64'd1);
    @(negedge clk);
    rd_check("count_2", 5'd4, 64'd2);

    // ---- table-driven write/read ----
    for (int i = 0; i < 18; i++) begin
      wr(tbl[i].waddr, tbl[i].wdata);
      rd_check($sformatf("tbl[%0d]", i), tbl[i].raddr, tbl[i].exp);
    end
    check("vbc_34", 64'(vec_bank_count), 64'd3);
    check("log_out", 64'(log_control), 64'd1);
    ren = 1'b0; raddr = 5'd1;
    #1;
    check("ren_low", rdata, 64'd0);

    // ---- width / parameter handling ----
    wr(5'd0, 64'hff);
    rd_check("st64_ef", 5'd0, 64'hf3);
    rd32_check("st32_ef", 5'd0, 32'hf1);
    wr(5'd15, 64'h77);
    rd32_check("k3_32", 5'd15, 32'h0);
    wr(5'd16, 64'h8000_0000);
    rd32_check("toh32", 5'd16, 32'h8000_0000);
    rd_check("toh64_sext", 5'd16, 64'hffff_ffff_8000_0000);
    @(negedge clk);
    exception = 1'b1; cause = 5'd7; pc = 64'hffff_ffff_8000_0004;
    @(negedge clk);
    exception = 1'b0;
    rd32_check("epc32", 5'd1, 32'h8000_0004);
    rd_check("epc64", 5'd1, 64'hffff_ffff_8000_0004);
    rd_check("bva_keep", 5'd2, 64'hdead_beef_0000_0001);

    // ---- traps ----
    wr(5'd0, 64'hc0);
    #1 check("err_before", 64'(error_mode), 64'd0);
    @(negedge clk);
    exception = 1'b1; cause = 5'd3; pc = 64'h8000_1000;
    wen = 1'b1; waddr = 5'd12; wdata = 64'h0;
    @(negedge clk);
    exception = 1'b0; wen = 1'b0;
    #1 check("err_set", 64'(error_mode), 64'd1);
    check("et0_status", 64'(status), 64'hc0);
    rd_check("et0_epc", 5'd1, 64'hffff_ffff_8000_0004);
    rd_check("et0_cause", 5'd6, 64'd7);
    rd_check("et0_k0", 5'd12, 64'haaaa_5555_aaaa_5555);
    wr(5'd0, 64'hc1);
    @(negedge clk);
    exception = 1'b1; cause = 5'd3; pc = 64'h8000_1000;
    badvaddr_wen = 1'b1; badvaddr = 64'hcafe;
    @(negedge clk);
    exception = 1'b0; badvaddr_wen = 1'b0;
    #1 check("trap_status", 64'(status), 64'he0);
    rd_check("trap_epc", 5'd1, 64'h8000_1000);
    rd_check("trap_cause", 5'd6, 64'd3);
    rd_check("trap_bva", 5'd2, 64'hcafe);
    check("err_sticky", 64'(error_mode), 64'd1);
    @(negedge clk);
    eret = 1'b1; wen = 1'b1; waddr = 5'd12; wdata = 64'h0;
    @(negedge clk);
    eret = 1'b0; wen = 1'b0;
    #1 check("eret_status", 64'(status), 64'hc1);
    rd_check("eret_k0", 5'd12, 64'haaaa_5555_aaaa_5555);

    // ---- compare timer ----
    wr(5'd4, 64'd10);
    wr(5'd5, 64'd20);
    wr(5'd0, 64'h80e1);
    found = 1'b0;
    raddr = 5'd4; ren = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      #1;
      check($sformatf("tmr_int@%0d", rdata), 64'(interrupt), 64'(rdata >= 64'd20));
      if (rdata == 64'd20) begin
        found = 1'b1;
        check("tmr_cause", 64'(interrupt_cause), 64'd23);
      end else begin
        @(negedge clk);
      end
    end
    if (!found) check("tmr_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    #1 check("tmr_sticky", 64'(interrupt), 64'd1);
    rd_check("tmr_ip", 5'd7, 64'h80);
    wr(5'd5, 64'd100);
    #1 check("tmr_clr_int", 64'(interrupt), 64'd0);
    rd_check("tmr_clr_ip", 5'd7, 64'h0);

    // ---- mailboxes ----
    wr(5'd16, 64'h11);
    rd_check("fh0_clr", 5'd24, 64'h0);
    check("valid_11", 64'(htif_tohost_valid), 64'h3);
    @(negedge clk);
    wen = 1'b1; waddr = 5'd17; wdata = 64'h55;
    htif_fromhost_wen = 1'b1; htif_ch = 3'd1; htif_fromhost = 32'haa;
    #1 check("htoh_block", 64'(htif_tohost), 64'h0);
    @(negedge clk);
    wen = 1'b0; htif_fromhost_wen = 1'b0; htif_ch = 3'd0;
    rd_check("race_fh1", 5'd25, 64'haa);
    rd_check("race_th1", 5'd17, 64'h0);
    rd_check("race_th0", 5'd16, 64'h11);
    check("race_valid", 64'(htif_tohost_valid), 64'h1);
    check("htoh_ch0", 64'(htif_tohost), 64'h11);
    @(negedge clk);
    htif_fromhost_wen = 1'b1; htif_ch = 3'd0; htif_fromhost = 32'hbb;
    @(negedge clk);
    htif_fromhost_wen = 1'b0;
    rd_check("host_fh0", 5'd24, 64'hbb);
    check("valid_00", 64'(htif_tohost_valid), 64'h0);
    @(negedge clk);
    htif_fromhost_wen = 1'b1; htif_ch = 3'd3; htif_fromhost = 32'hcc;
    @(negedge clk);
    htif_fromhost_wen = 1'b0;
    #1 check("htoh_oob", 64'(htif_tohost), 64'h0);
    rd_check("oob_fh0", 5'd24, 64'hbb);
    wr(5'd25, 64'h1234);
    rd_check("core_fh1", 5'd25, 64'h1234);

    // ---- external interrupts ----
    wr(5'd0, 64'h04c1);
    #1 check("irq_none", 64'(interrupt), 64'd0);
    @(negedge clk);
    irq_ext = 7'b0000100;
    #1 check("irq_lat", 64'(interrupt), 64'd0);
    @(negedge clk);
    #1 check("irq_int", 64'(interrupt), 64'd1);
    check("irq_cause18", 64'(interrupt_cause), 64'd18);
    raddr = 5'd7; ren = 1'b1;
    #1 check("irq_ip", rdata & 64'h7f, 64'h4);
    wr(5'd0, 64'h14c1);
    irq_ext = 7'b0010100;
    @(negedge clk);
    #1 check("irq_lowest", 64'(interrupt_cause), 64'd18);
    irq_ext = 7'b0010000;
    @(negedge clk);
    #1 check("irq_cause20", 64'(interrupt_cause), 64'd20);
    wr(5'd0, 64'h14c0);
    #1 check("irq_et0", 64'(interrupt), 64'd0);
    check("irq_et0_cause", 64'(interrupt_cause), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
